// File: rtl/oven_pkg.sv
// Shared types, default parameters and helpers for the oven zone controller.
package oven_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StHeat  = 3'd1,
    StHold  = 3'd2,
    StDone  = 3'd3,
    StFault = 3'd4
  } oven_state_e;

  localparam int unsigned DefTempW    = 8;
  localparam int unsigned DefTimeW    = 4;
  localparam int unsigned DefHyst     = 2;
  localparam int unsigned DefMaxDelta = 20;
  localparam int unsigned DefTickDiv  = 50_000_000;

  // Returns {high, set, low} for cur against ref_t; callers zero-extend.
  function automatic logic [2:0] temp_cmp(input logic [31:0] cur, input logic [31:0] ref_t);
    return {cur > ref_t, cur == ref_t, cur < ref_t};
  endfunction

endpackage

// File: rtl/oven_tick_gen.sv
// Time-base divider: tick is a one-clk pulse on the cycle the counter wraps.
module oven_tick_gen #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CntW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            wrap;

  assign wrap = (cnt_q == CntW'(TICK_DIV - 1));
  assign tick = en & ~clr & wrap;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = wrap ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/oven_zone_ctrl.sv
// Single-zone oven controller: latch setpoints on start, preheat, hold with
// hysteresis while counting down, then DONE; over-temperature forces FAULT.
module oven_zone_ctrl
  import oven_pkg::*;
#(
  parameter int unsigned TEMP_W    = DefTempW,
  parameter int unsigned TIME_W    = DefTimeW,
  parameter int unsigned HYST      = DefHyst,
  parameter int unsigned MAX_DELTA = DefMaxDelta,
  parameter int unsigned TICK_DIV  = DefTickDiv
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [TEMP_W-1:0] current_temp,
  input  logic [TEMP_W-1:0] set_temp,
  input  logic [TIME_W-1:0] set_time,
  output logic              heater,
  output logic [TIME_W-1:0] remaining,
  output logic              done,
  output logic              fault,
  output logic              led_start,
  output logic              led_stop,
  output logic              led_high,
  output logic              led_set,
  output logic              led_low
);

  oven_state_e       state_q, state_d;
  logic              start_q, stop_q;
  logic [TEMP_W-1:0] sp_q, sp_d;
  logic [TIME_W-1:0] tm_q, tm_d;
  logic [TIME_W-1:0] rem_q, rem_d;
  logic              heater_q, heater_d;
  logic              busy_d;
  logic [2:0]        cmp_q, cmp_d;

  logic              start_e, stop_e;
  logic              tick, tick_clr;
  logic [TEMP_W:0]   fault_lim;
  logic              over;
  logic [TEMP_W-1:0] lo;

  assign start_e = start & ~start_q;
  assign stop_e  = stop & ~stop_q;

  // One extra bit so sp + MAX_DELTA never wraps.
  assign fault_lim = {1'b0, sp_q} + (TEMP_W + 1)'(MAX_DELTA);
  assign over      = ({1'b0, current_temp} > fault_lim);
  assign lo        = (sp_q >= TEMP_W'(HYST)) ? sp_q - TEMP_W'(HYST) : '0;

  oven_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (tick_clr),
    .en   (state_q == StHold),
    .tick (tick)
  );

  always_comb begin
    state_d  = state_q;
    sp_d     = sp_q;
    tm_d     = tm_q;
    rem_d    = rem_q;
    tick_clr = 1'b0;

    if (stop_e) begin
      state_d  = StIdle;
      tick_clr = 1'b1;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start_e && (set_temp != '0) && (set_time != '0)) begin
            sp_d    = set_temp;
            tm_d    = set_time;
            state_d = StHeat;
          end
        end
        StHeat: begin
          if (over) begin
            state_d = StFault;
          end else if (current_temp >= sp_q) begin
            state_d  = StHold;
            rem_d    = tm_q;
            tick_clr = 1'b1;
          end
        end
        StHold: begin
          if (over) begin
            state_d = StFault;
          end else if (tick) begin
            rem_d = rem_q - TIME_W'(1);
            if (rem_q == TIME_W'(1)) state_d = StDone;
          end
        end
        StFault: ;
        default: state_d = StIdle;
      endcase
    end

    heater_d = 1'b0;
    unique case (state_d)
      StHeat: heater_d = 1'b1;
      StHold: begin
        if (current_temp >= sp_d)  heater_d = 1'b0;
        else if (current_temp < lo) heater_d = 1'b1;
        else                        heater_d = heater_q;
      end
      default: heater_d = 1'b0;
    endcase

    // remaining is only meaningful while holding.
    if (state_d != StHold) rem_d = '0;

    busy_d = (state_d == StHeat) || (state_d == StHold);
    cmp_d  = temp_cmp(32'(current_temp), busy_d ? 32'(sp_d) : 32'(set_temp));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
      sp_q      <= '0;
      tm_q      <= '0;
      rem_q     <= '0;
      heater_q  <= 1'b0;
      done      <= 1'b0;
      fault     <= 1'b0;
      led_start <= 1'b0;
      led_stop  <= 1'b1;
      cmp_q     <= '0;
    end else begin
      state_q   <= state_d;
      start_q   <= start;
      stop_q    <= stop;
      sp_q      <= sp_d;
      tm_q      <= tm_d;
      rem_q     <= rem_d;
      heater_q  <= heater_d;
      done      <= (state_d == StDone);
      fault     <= (state_d == StFault);
      led_start <= busy_d;
      led_stop  <= ~busy_d;
      cmp_q     <= cmp_d;
    end
  end

  assign heater    = heater_q;
  assign remaining = rem_q;
  assign led_high  = cmp_q[2];
  assign led_set   = cmp_q[1];
  assign led_low   = cmp_q[0];

endmodule

// File: tb/tb_oven_zone_ctrl.sv
// Self-checking bench for oven_zone_ctrl: directed vector table, a reset
// sequence, and randomized stimulus against a behavioural model.
module tb_oven_zone_ctrl;

  localparam int HYST      = 2;
  localparam int MAX_DELTA = 20;
  localparam int TICK_DIV  = 4;
  localparam int LO = 1, EQ = 2, HI = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0, stop = 1'b0;
  logic [7:0] current_temp = '0, set_temp = '0;
  logic [3:0] set_time = '0;
  logic       heater, done, fault, led_start, led_stop, led_high, led_set, led_low;
  logic [3:0] remaining;

  int n_chk = 0;
  int n_fail = 0;

  oven_zone_ctrl #(
    .TEMP_W   (8),
    .TIME_W   (4),
    .HYST     (HYST),
    .MAX_DELTA(MAX_DELTA),
    .TICK_DIV (TICK_DIV)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .current_temp(current_temp),
    .set_temp    (set_temp),
    .set_time    (set_time),
    .heater      (heater),
    .remaining   (remaining),
    .done        (done),
    .fault       (fault),
    .led_start   (led_start),
    .led_stop    (led_stop),
    .led_high    (led_high),
    .led_set     (led_set),
    .led_low     (led_low)
  );

  always #5 clk = ~clk;

  // Behavioural model: mode 0 idle, 1 heat, 2 hold, 3 done, 4 fault.
  int m_mode, m_sp, m_tm, m_rem, m_heat, m_elapsed, m_cmp;
  bit m_sprev, m_pprev;

  task automatic model_reset();
    m_mode = 0; m_sp = 0; m_tm = 0; m_rem = 0; m_heat = 0; m_elapsed = 0;
    m_sprev = 0; m_pprev = 0;
  endtask

  task automatic model_step(input bit s, input bit p, input int cur, input int st,
                            input int tim);
    bit se, pe;
    int lo, ref_t;
    se = s && !m_sprev;
    pe = p && !m_pprev;
    m_sprev = s;
    m_pprev = p;
    lo = m_sp - HYST;
    if (lo < 0) lo = 0;
    if (pe) m_mode = 0;
    else if (m_mode == 0 || m_mode == 3) begin
      if (se && st != 0 && tim != 0) begin
        m_sp = st; m_tm = tim; m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (cur > m_sp + MAX_DELTA) m_mode = 4;
      else if (cur >= m_sp) begin
        m_mode = 2; m_rem = m_tm; m_elapsed = 0;
      end
    end else if (m_mode == 2) begin
      if (cur > m_sp + MAX_DELTA) m_mode = 4;
      else begin
        m_elapsed++;
        if (m_elapsed % TICK_DIV == 0) begin
          m_rem--;
          if (m_rem == 0) m_mode = 3;
        end
      end
    end
    if (m_mode == 1) m_heat = 1;
    else if (m_mode == 2) begin
      if (cur >= m_sp) m_heat = 0;
      else if (cur < lo) m_heat = 1;
    end else m_heat = 0;
    if (m_mode != 2) m_rem = 0;
    ref_t = (m_mode == 1 || m_mode == 2) ? m_sp : st;
    m_cmp = (cur > ref_t) ? HI : (cur == ref_t) ? EQ : LO;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int e_heat, input int e_rem, input int e_done,
                         input int e_fault, input int e_ls, input int e_cmp);
    chk({tag, " heater"}, 32'(heater), e_heat);
    chk({tag, " remaining"}, 32'(remaining), e_rem);
    chk({tag, " done"}, 32'(done), e_done);
    chk({tag, " fault"}, 32'(fault), e_fault);
    chk({tag, " led_start"}, 32'(led_start), e_ls);
    chk({tag, " led_stop"}, 32'(led_stop), 32'(e_ls == 0));
    chk({tag, " leds_cmp"}, 32'({led_high, led_set, led_low}), e_cmp);
  endtask

  // Model sees the inputs held during the cycle, then outputs are sampled 1 after the edge.
  task automatic cycle();
    model_step(start, stop, int'(current_temp), int'(set_temp), int'(set_time));
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int start, stop, cur, st, tim;
    int heat, rem, done, fault, ls, cmp;
  } vec_t;

  vec_t vec[44];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cur_i, base;
    vec[0]  = '{0, 0,   5,  35, 3,  0, 0, 0, 0, 0, LO};
    vec[1]  = '{1, 0,   5,  35, 3,  1, 0, 0, 0, 1, LO};
    vec[2]  = '{1, 0,   5,  35, 3,  1, 0, 0, 0, 1, LO};
    vec[3]  = '{0, 0,  35,  35, 3,  0, 3, 0, 0, 1, EQ};
    vec[4]  = '{0, 0,  36,  35, 3,  0, 3, 0, 0, 1, HI};
    vec[5]  = '{0, 0,  34,  35, 3,  0, 3, 0, 0, 1, LO};
    vec[6]  = '{0, 0,  32,  35, 3,  1, 3, 0, 0, 1, LO};
    vec[7]  = '{0, 0,  32,  35, 3,  1, 2, 0, 0, 1, LO};
    vec[8]  = '{0, 0,  33,  35, 3,  1, 2, 0, 0, 1, LO};
    vec[9]  = '{0, 0,  35,  35, 3,  0, 2, 0, 0, 1, EQ};
    vec[10] = '{0, 0,  35,  35, 3,  0, 2, 0, 0, 1, EQ};
    vec[11] = '{0, 0,  35,  35, 3,  0, 1, 0, 0, 1, EQ};
    vec[12] = '{0, 0,  35,  35, 3,  0, 1, 0, 0, 1, EQ};
    vec[13] = '{0, 0,  35,  35, 3,  0, 1, 0, 0, 1, EQ};
    vec[14] = '{0, 0,  35,  35, 3,  0, 1, 0, 0, 1, EQ};
    vec[15] = '{0, 0,  35,  35, 3,  0, 0, 1, 0, 0, EQ};
    vec[16] = '{0, 0,  35,  35, 3,  0, 0, 1, 0, 0, EQ};
    vec[17] = '{1, 0,  35,  35, 3,  1, 0, 0, 0, 1, EQ};
    vec[18] = '{1, 0,  35,  35, 3,  0, 3, 0, 0, 1, EQ};
    vec[19] = '{0, 0,  55,  35, 3,  0, 3, 0, 0, 1, HI};
    vec[20] = '{0, 0,  56,  35, 3,  0, 0, 0, 1, 0, HI};
    vec[21] = '{0, 0,  56,  35, 3,  0, 0, 0, 1, 0, HI};
    vec[22] = '{1, 0,  56,  35, 3,  0, 0, 0, 1, 0, HI};
    vec[23] = '{1, 1,  56,  35, 3,  0, 0, 0, 0, 0, HI};
    vec[24] = '{0, 0,   5,  35, 3,  0, 0, 0, 0, 0, LO};
    vec[25] = '{1, 0,   5,  35, 3,  1, 0, 0, 0, 1, LO};
    vec[26] = '{0, 0,   5,  35, 3,  1, 0, 0, 0, 1, LO};
    vec[27] = '{1, 1,   5,  35, 3,  0, 0, 0, 0, 0, LO};
    vec[28] = '{1, 0,   5,  35, 3,  0, 0, 0, 0, 0, LO};
    vec[29] = '{0, 0,   5,  35, 0,  0, 0, 0, 0, 0, LO};
    vec[30] = '{1, 0,   5,  35, 0,  0, 0, 0, 0, 0, LO};
    vec[31] = '{0, 0, 255, 250, 2,  0, 0, 0, 0, 0, HI};
    vec[32] = '{1, 0, 255, 250, 2,  1, 0, 0, 0, 1, HI};
    vec[33] = '{1, 0, 255, 250, 2,  0, 2, 0, 0, 1, HI};
    vec[34] = '{0, 0, 255, 250, 2,  0, 2, 0, 0, 1, HI};
    vec[35] = '{0, 0, 255, 250, 2,  0, 2, 0, 0, 1, HI};
    vec[36] = '{0, 1, 255, 250, 2,  0, 0, 0, 0, 0, HI};
    vec[37] = '{0, 0,   1,   1, 3,  0, 0, 0, 0, 0, EQ};
    vec[38] = '{1, 0,   1,   1, 3,  1, 0, 0, 0, 1, EQ};
    vec[39] = '{0, 0,   0,   1, 3,  1, 0, 0, 0, 1, LO};
    vec[40] = '{0, 0,   1,   1, 3,  0, 3, 0, 0, 1, EQ};
    vec[41] = '{0, 0,   0,   1, 3,  0, 3, 0, 0, 1, LO};
    vec[42] = '{0, 0,   0,   1, 3,  0, 3, 0, 0, 1, LO};
    vec[43] = '{0, 1,   0,   1, 3,  0, 0, 0, 0, 0, LO};

    model_reset();
    #1 rst_n = 1'b0;
    #3;
    chk("reset heater", 32'(heater), 0);
    chk("reset remaining", 32'(remaining), 0);
    chk("reset done", 32'(done), 0);
    chk("reset fault", 32'(fault), 0);
    chk("reset led_start", 32'(led_start), 0);
    chk("reset led_stop", 32'(led_stop), 1);
    #8 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 44; i++) begin
      start        = (vec[i].start != 0);
      stop         = (vec[i].stop != 0);
      current_temp = 8'(vec[i].cur);
      set_temp     = 8'(vec[i].st);
      set_time     = 4'(vec[i].tim);
      cycle();
      chk_all($sformatf("vec%0d", i), vec[i].heat, vec[i].rem, vec[i].done, vec[i].fault,
              vec[i].ls, vec[i].cmp);
    end

    // Asynchronous reset in the middle of HOLD.
    stop = 1'b0; start = 1'b0; current_temp = 8'd10; set_temp = 8'd40; set_time = 4'd5;
    cycle();
    start = 1'b1;
    cycle();
    start = 1'b0; current_temp = 8'd40;
    cycle();
    chk("rst_seq remaining", 32'(remaining), 5);
    current_temp = 8'd30;
    cycle();
    chk("rst_seq heater", 32'(heater), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst heater", 32'(heater), 0);
    chk("async_rst remaining", 32'(remaining), 0);
    chk("async_rst done", 32'(done), 0);
    chk("async_rst led_start", 32'(led_start), 0);
    chk("async_rst led_stop", 32'(led_stop), 1);
    @(posedge clk);
    #3 rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    cycle();
    chk_all("post_rst", m_heat, m_rem, 0, 0, 0, m_cmp);

    // Randomized phase against the model.
    set_temp = 8'd35; set_time = 4'd3;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) start = ~start;
      stop = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 3))
          0:       set_temp = 8'd0;
          3:       set_temp = 8'($urandom_range(245, 255));
          default: set_temp = 8'($urandom_range(20, 60));
        endcase
      end
      if ($urandom_range(0, 15) == 0) set_time = 4'($urandom_range(0, 4));
      base = (m_sp > 8) ? m_sp - 8 : 0;
      if ($urandom_range(0, 31) == 0) cur_i = $urandom_range(0, 255);
      else cur_i = base + $urandom_range(0, 24);
      if (cur_i > 255) cur_i = 255;
      current_temp = 8'(cur_i);
      cycle();
      chk_all($sformatf("rnd%0d", n), m_heat, m_rem, 32'(m_mode == 3), 32'(m_mode == 4),
              32'(m_mode == 1 || m_mode == 2), m_cmp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
